// File: rtl/discharge_state_ctrl.sv
// -----------------------------------------------------------------------------
// discharge_state_ctrl
//
// Pulse-sequencing FSM for the EDM discharge loop. Each pulse is a sequence of
// three phases:
//   1. wait for breakdown, with the open-circuit voltage applied;
//   2. discharge on-time, through interleaved buck phases or through the
//      resistor;
//   3. deionisation, with all gates off.
// The controller supports continuous and single-shot operation.
//
// Parameters
//   TON_CYCLES   : discharge on-time in clk cycles (>=1)
//   TOFF_CYCLES  : deionisation time in clk cycles (>=1)
//   WAIT_TIMEOUT : max cycles spent waiting for breakdown (>=1)
//   BUCK_PERIOD  : buck PWM period in cycles (even, >=2)
//   BUCK_DUTY    : high cycles per buck phase (<= BUCK_PERIOD)
//
// Ports
//   clk            : system clock
//   rst            : synchronous reset, active-high
//   discharge_en   : global machining enable
//   single_mode    : 1 = single-shot, 0 = continuous
//   single_start   : one-cycle start request (single mode, IDLE only)
//   discharge_mode : 0 = buck interleave, 1 = resistor discharge
//   is_breakdown   : breakdown flag from the detector
//   current_state  : FSM state code (00 idle, 01 wait, 02 buck, 04 res, 80 deion)
//   vol_gate       : open-circuit voltage switch
//   buck_gate_a/_b : buck phases A and B; B is shifted by half a period
//   res_gate       : resistor discharge switch
//   pulse_count    : number of discharges started, saturating
//   timeout_pulse  : one-cycle strobe when waiting for breakdown times out
//
// All outputs are registered and decoded from the next state. As a result,
// the gates change on the same edge as current_state.
// -----------------------------------------------------------------------------
module discharge_state_ctrl #(
  parameter logic [15:0] TON_CYCLES   = 16'd500,
  parameter logic [15:0] TOFF_CYCLES  = 16'd1000,
  parameter logic [31:0] WAIT_TIMEOUT = 32'd10000000,
  parameter logic [15:0] BUCK_PERIOD  = 16'd100,
  parameter logic [15:0] BUCK_DUTY    = 16'd40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        discharge_en,
  input  logic        single_mode,
  input  logic        single_start,
  input  logic        discharge_mode,
  input  logic        is_breakdown,
  output logic [7:0]  current_state,
  output logic        vol_gate,
  output logic        buck_gate_a,
  output logic        buck_gate_b,
  output logic        res_gate,
  output logic [31:0] pulse_count,
  output logic        timeout_pulse
);

  // State codes double as the externally visible current_state value.
  localparam logic [7:0] ST_IDLE  = 8'h00;
  localparam logic [7:0] ST_WAIT  = 8'h01;
  localparam logic [7:0] ST_BUCK  = 8'h02;
  localparam logic [7:0] ST_RES   = 8'h04;
  localparam logic [7:0] ST_DEION = 8'h80;

  // Terminal counts. A counter that starts at 0 on entry and leaves at
  // N-1 gives a dwell of exactly N cycles.
  localparam logic [15:0] TON_LAST    = TON_CYCLES - 16'd1;
  localparam logic [15:0] TOFF_LAST   = TOFF_CYCLES - 16'd1;
  localparam logic [31:0] WAIT_LAST   = WAIT_TIMEOUT - 32'd1;
  localparam logic [15:0] PERIOD_LAST = BUCK_PERIOD - 16'd1;
  localparam logic [15:0] HALF_PERIOD = BUCK_PERIOD >> 1;

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  logic [7:0]  state_q, state_d;
  logic        mode_q, mode_d;          // discharge_mode latched at WAIT entry
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] on_cnt_q, on_cnt_d;
  logic [15:0] off_cnt_q, off_cnt_d;
  logic [15:0] phase_q, phase_d;        // buck PWM phase, 0..BUCK_PERIOD-1
  logic [31:0] pulse_cnt_q, pulse_cnt_d;
  logic        timeout_q, timeout_d;

  // Registered gate outputs
  logic        vol_q, res_q;
  logic [1:0]  buck_q;                  // [0] = phase A, [1] = phase B
  logic [1:0]  buck_on_d;

  logic        in_on_q;                 // currently in BUCK or RES
  logic        stay;                    // no state change this cycle

  assign in_on_q = (state_q == ST_BUCK) || (state_q == ST_RES);
  assign stay    = (state_d == state_q);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    timeout_d   = 1'b0;
    pulse_cnt_d = pulse_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // In single mode a start request is needed. Without enable,
        // the request is dropped.
        if (discharge_en && (!single_mode || single_start)) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (!discharge_en) begin
          state_d = ST_DEION;
        end else if (is_breakdown) begin
          // Breakdown takes priority over a coincident timeout.
          state_d = mode_q ? ST_RES : ST_BUCK;
          if (pulse_cnt_q != 32'hFFFF_FFFF) begin
            pulse_cnt_d = pulse_cnt_q + 32'd1;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = ST_DEION;
          timeout_d = 1'b1;
        end
      end

      ST_BUCK, ST_RES: begin
        if (!discharge_en || (on_cnt_q == TON_LAST)) begin
          state_d = ST_DEION;
        end
      end

      ST_DEION: begin
        // Deionisation always runs to completion. The decision to go
        // on is taken only at its end, so a mode change made
        // mid-pulse applies to the next pulse.
        if (off_cnt_q == TOFF_LAST) begin
          state_d = (discharge_en && !single_mode) ? ST_WAIT : ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Dwell counters: cleared on every state change, incremented while staying.
  // ---------------------------------------------------------------------------
  always_comb begin
    wait_cnt_d = '0;
    on_cnt_d   = '0;
    off_cnt_d  = '0;
    phase_d    = '0;
    mode_d     = mode_q;

    if ((state_q == ST_WAIT) && stay) begin
      wait_cnt_d = wait_cnt_q + 32'd1;
    end
    if (in_on_q && stay) begin
      on_cnt_d = on_cnt_q + 16'd1;
    end
    if ((state_q == ST_DEION) && stay) begin
      off_cnt_d = off_cnt_q + 16'd1;
    end
    if ((state_q == ST_BUCK) && stay) begin
      phase_d = (phase_q == PERIOD_LAST) ? 16'd0 : phase_q + 16'd1;
    end
    // The discharge kind is frozen for the whole pulse from WAIT entry.
    if ((state_d == ST_WAIT) && (state_q != ST_WAIT)) begin
      mode_d = discharge_mode;
    end
  end

  // ---------------------------------------------------------------------------
  // Buck phase decode. Phase gi sees the PWM counter advanced by
  // gi * BUCK_PERIOD/2, taken modulo BUCK_PERIOD. The sum is kept below
  // 2*BUCK_PERIOD, so a single conditional subtract is enough for the wrap.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buck_phase
      localparam logic [15:0] OFFSET = (gi == 0) ? 16'd0 : HALF_PERIOD;
      logic [16:0] shifted;
      logic [15:0] wrapped;

      assign shifted = {1'b0, phase_d} + {1'b0, OFFSET};
      assign wrapped = (shifted >= {1'b0, BUCK_PERIOD})
                       ? 16'(shifted - {1'b0, BUCK_PERIOD})
                       : shifted[15:0];
      assign buck_on_d[gi] = (state_d == ST_BUCK) && (wrapped < BUCK_DUTY);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      wait_cnt_q  <= '0;
      on_cnt_q    <= '0;
      off_cnt_q   <= '0;
      phase_q     <= '0;
      pulse_cnt_q <= '0;
      timeout_q   <= 1'b0;
      vol_q       <= 1'b0;
      res_q       <= 1'b0;
      buck_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      wait_cnt_q  <= wait_cnt_d;
      on_cnt_q    <= on_cnt_d;
      off_cnt_q   <= off_cnt_d;
      phase_q     <= phase_d;
      pulse_cnt_q <= pulse_cnt_d;
      timeout_q   <= timeout_d;
      // Gates are decoded from the next state. Only one gate group can
      // be active at a time.
      vol_q       <= (state_d == ST_WAIT);
      res_q       <= (state_d == ST_RES);
      buck_q      <= buck_on_d;
    end
  end

  assign current_state = state_q;
  assign vol_gate      = vol_q;
  assign res_gate      = res_q;
  assign buck_gate_a   = buck_q[0];
  assign buck_gate_b   = buck_q[1];
  assign pulse_count   = pulse_cnt_q;
  assign timeout_pulse = timeout_q;

endmodule
